// File: rtl/acumulador_pkg.sv
// Shared constants for the accumulator controller: default widths and the
// FSM state encoding used by the controller and its integration top.
package acumulador_pkg;

  localparam int TAMANHO_DEF = 16;
  localparam int ADDR_W_DEF  = 8;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CLR   = 3'd1;
  localparam logic [ST_W-1:0] ST_FETCH = 3'd2;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd3;
  localparam logic [ST_W-1:0] ST_XFER  = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

  function automatic logic is_busy(input logic [ST_W-1:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/acumulador_ctrl.sv
// Sequencer for a clear/load/transfer accumulator summing Count consecutive
// memory words starting at BaseAddr; every output is registered.
module acumulador_ctrl
  import acumulador_pkg::*;
#(
  parameter int TAMANHO = TAMANHO_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-1:0] Count,
  output logic [ADDR_W-1:0] Addr,
  output logic              Load,
  output logic              Transfer,
  output logic              Clear,
  output logic              Busy,
  output logic              Done
);

  // The data width only matters to the paired accumulator; reject nonsense here.
  if (TAMANHO < 1) begin : g_bad_width
    $error("acumulador_ctrl: TAMANHO must be positive");
  end

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              load_q, load_d;
  logic              xfer_q, xfer_d;
  logic              clear_n_q, clear_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, address and counter logic; Abort overrides every transition.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          state_d = ST_CLR;
          addr_d  = BaseAddr;
          cnt_d   = Count;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_FETCH: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          // Address wraps naturally at 2^ADDR_W.
          cnt_d   = cnt_q - ONE;
          addr_d  = addr_q + ONE;
          state_d = (cnt_q != ONE) ? ST_FETCH : ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so the flops present a Moore decode.
  always_comb begin
    load_d    = (state_d == ST_LOAD);
    xfer_d    = (state_d == ST_XFER);
    clear_n_d = (state_d != ST_CLR);
    busy_d    = is_busy(state_d);
    done_d    = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      xfer_q    <= 1'b0;
      clear_n_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      xfer_q    <= xfer_d;
      clear_n_q <= clear_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Addr     = addr_q;
  assign Load     = load_q;
  assign Transfer = xfer_q;
  assign Clear    = clear_n_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_acumulador_ctrl.sv
// Directed bench: controller plus a behavioural memory (1-cycle read) and
// clear/load/transfer accumulator.
module tb_acumulador_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [7:0]  BaseAddr = 8'h00;
  logic [7:0]  Count = 8'h00;
  logic [7:0]  Addr;
  logic        Load, Transfer, Clear, Busy, Done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem [256];
  logic [15:0] mem_q = 16'h0;
  logic [15:0] acc_a = 16'h0;
  logic [15:0] acc_b = 16'h0;
  logic [7:0]  seen_addr [$];

  acumulador_ctrl #(.TAMANHO(16), .ADDR_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
    .BaseAddr(BaseAddr), .Count(Count), .Addr(Addr), .Load(Load),
    .Transfer(Transfer), .Clear(Clear), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Environment: synchronous memory and the accumulator being sequenced.
  always @(posedge Clock) begin
    mem_q <= mem[Addr];
    if (!Clear) begin
      acc_a <= 16'h0;
      acc_b <= 16'h0;
    end else begin
      if (Load)     acc_b <= mem_q;
      if (Transfer) acc_a <= acc_a + acc_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Start a sum in the current cycle t; returns the cycle offset of Done (-1 on timeout).
  task automatic run_sum(input logic [7:0] base, input logic [7:0] cnt,
                         input int restart_at, output int lat);
    bit overlap = 1'b0;
    int i;
    seen_addr.delete();
    BaseAddr = base;
    Count    = cnt;
    Start    = 1'b1;
    step();
    Start = 1'b0;
    i   = 1;
    lat = -1;
    while (lat < 0 && i < 800) begin
      if (Load) seen_addr.push_back(Addr);
      if (Load && Transfer) overlap = 1'b1;
      if (Done) begin
        lat = i;
      end else begin
        if (i == restart_at) begin
          Start = 1'b1; BaseAddr = 8'h30; Count = 8'd1;
        end
        step();
        Start = 1'b0;
        i++;
      end
    end
    chk("no_load_xfer_overlap", {31'b0, overlap}, 32'd0);
    step();
    chk("done_single_cycle", {31'b0, Done}, 32'd0);
    chk("idle_after_done", {31'b0, Busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, {24'b0, Addr}, 32'h0);
    chk({tag, "_load"}, {31'b0, Load}, 32'd0);
    chk({tag, "_xfer"}, {31'b0, Transfer}, 32'd0);
    chk({tag, "_clear"}, {31'b0, Clear}, 32'd1);
    chk({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, Done}, 32'd0);
  endtask

  initial begin
    int lat;
    int loads;
    bit saw_done;
    int dones;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0;
    mem[8'h10] = 16'd5;  mem[8'h11] = 16'd7;  mem[8'h12] = 16'd9;
    mem[8'hFE] = 16'd100; mem[8'hFF] = 16'd200; mem[8'h00] = 16'd300;
    mem[8'h20] = 16'd11; mem[8'h21] = 16'd22; mem[8'h22] = 16'd33; mem[8'h23] = 16'd44;
    mem[8'h30] = 16'd1000;

    step(); step();
    Reset = 1'b0;
    chk_reset_vals("reset");

    // Start and Abort together in IDLE stays idle.
    Start = 1'b1; Abort = 1'b1; BaseAddr = 8'h10; Count = 8'd3;
    step();
    Start = 1'b0; Abort = 1'b0;
    chk("start_abort_idle_busy", {31'b0, Busy}, 32'd0);
    chk("start_abort_idle_clear", {31'b0, Clear}, 32'd1);

    // Basic three-word sum: 5+7+9.
    run_sum(8'h10, 8'd3, -1, lat);
    chk("sum3_latency", lat, 32'd11);
    chk("sum3_acc", {16'b0, acc_a}, 32'd21);
    chk("sum3_nloads", seen_addr.size(), 32'd3);

    // Count=0 after a previous sum: clear pulse then immediate Done.
    BaseAddr = 8'h10; Count = 8'd0; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("cnt0_clear_low", {31'b0, Clear}, 32'd0);
    chk("cnt0_busy", {31'b0, Busy}, 32'd1);
    step();
    chk("cnt0_done_t2", {31'b0, Done}, 32'd1);
    chk("cnt0_clear_back", {31'b0, Clear}, 32'd1);
    chk("cnt0_acc", {16'b0, acc_a}, 32'd0);
    step();
    chk("cnt0_idle", {31'b0, Busy}, 32'd0);

    // Address wrap FE, FF, 00.
    run_sum(8'hFE, 8'd3, -1, lat);
    chk("wrap_latency", lat, 32'd11);
    chk("wrap_nloads", seen_addr.size(), 32'd3);
    if (seen_addr.size() == 3) begin
      chk("wrap_addr0", {24'b0, seen_addr[0]}, 32'hFE);
      chk("wrap_addr1", {24'b0, seen_addr[1]}, 32'hFF);
      chk("wrap_addr2", {24'b0, seen_addr[2]}, 32'h00);
    end
    chk("wrap_acc", {16'b0, acc_a}, 32'd600);

    // Abort in the second LOAD of a four-word run.
    BaseAddr = 8'h20; Count = 8'd4; Start = 1'b1;
    step();
    Start = 1'b0;
    loads = 0;
    for (int i = 0; i < 40 && loads < 2; i++) begin
      if (Load) loads++;
      if (loads < 2) step();
    end
    chk("abort_reached_load2", loads, 32'd2);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_load", {31'b0, Load}, 32'd0);
    chk("abort_xfer", {31'b0, Transfer}, 32'd0);
    chk("abort_clear", {31'b0, Clear}, 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (Done) saw_done = 1'b1;
      step();
    end
    chk("abort_no_done", {31'b0, saw_done}, 32'd0);
    chk("abort_acc", {16'b0, acc_a}, 32'd11);

    // Start re-pulsed while busy must be ignored.
    run_sum(8'h10, 8'd3, 3, lat);
    chk("restart_latency", lat, 32'd11);
    chk("restart_acc", {16'b0, acc_a}, 32'd21);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (Done) dones++;
      step();
    end
    chk("restart_no_extra_done", dones, 32'd0);

    // Reset in the middle of XFER, then a clean run.
    BaseAddr = 8'h10; Count = 8'd3; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 20 && !Transfer; i++) step();
    chk("rst_mid_reached_xfer", {31'b0, Transfer}, 32'd1);
    Reset = 1'b1; Start = 1'b1; Abort = 1'b1;
    step();
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
    chk_reset_vals("rst_mid");
    run_sum(8'h10, 8'd3, -1, lat);
    chk("post_rst_latency", lat, 32'd11);
    chk("post_rst_acc", {16'b0, acc_a}, 32'd21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acumulador_ctrl.md
ACUMULADOR_CTRL -- requirements
Module: acumulador_ctrl

Interface
REQ-001 SHALL have parameter TAMANHO, default 16, the data width of the controlled accumulator (informational, no data path inside this block).
REQ-002 SHALL have parameter ADDR_W, default 8, the width of the memory address and word count.
REQ-003 SHALL have port Clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port Start  input  1  request to begin a summation; sampled only in IDLE.
REQ-006 SHALL have port Abort  input  1  cancel the operation in progress.
REQ-007 SHALL have port BaseAddr  input  ADDR_W  first memory word address; captured on an accepted Start.
REQ-008 SHALL have port Count  input  ADDR_W  number of words to sum; captured on an accepted Start.
REQ-009 SHALL have port Addr  output  ADDR_W  memory read address; registered.
REQ-010 SHALL have port Load  output  1  drives the accumulator B-register load enable.
REQ-011 SHALL have port Transfer  output  1  drives the accumulator A-register update enable.
REQ-012 SHALL have port Clear  output  1  drives the accumulator clear, active-low.
REQ-013 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port Done  output  1  one-cycle pulse when the sum is complete.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, CLR, FETCH, LOAD, XFER, DONE; all outputs are registered or decoded from state only.
REQ-016 SHALL go from IDLE to CLR on the cycle after Start=1, capturing BaseAddr into Addr and Count into a remaining-word counter.
REQ-017 SHALL drive Clear=0 only in CLR; Clear=1 in all other states.
REQ-018 SHALL go from CLR to FETCH when the counter is nonzero, and to DONE when it is zero.
REQ-019 SHALL present Addr in FETCH, a one-cycle synchronous memory read latency is designed in, and it SHALL go FETCH->LOAD unconditionally.
REQ-020 SHALL assert Load=1 only in LOAD, so the accumulator captures M at the end of LOAD, and it SHALL go LOAD->XFER.
REQ-021 SHALL assert Transfer=1 only in XFER, and it SHALL decrement the counter and increment Addr (mod 2^ADDR_W) on leaving XFER.
REQ-022 SHALL go from XFER to FETCH if the decremented counter is nonzero, else to DONE.
REQ-023 SHALL assert Done=1 for exactly the one cycle in DONE and then return to IDLE.
REQ-024 SHALL exhibit this latency: Start high at cycle t gives Done high at cycle t+2+3*Count; Count=0 gives Done at t+2 with the accumulator cleared.
REQ-025 SHALL ignore Start while Busy=1.
REQ-026 SHALL, on Abort=1 in any non-IDLE state, enter IDLE on the next edge with no Done pulse, leave the accumulator contents unchanged, and deassert Load and Transfer.
REQ-027 SHALL let Abort take priority over every other transition; Abort in IDLE has no effect, and Start and Abort both high in IDLE gives IDLE.
REQ-028 SHALL wrap the address from 2^ADDR_W-1 to 0 without error.
REQ-029 SHALL never assert Load and Transfer in the same cycle.

Reset
REQ-030 SHALL, on Reset=1 at a rising edge, enter IDLE with Addr=0, counter=0, Load=0, Transfer=0, Clear=1, Busy=0, Done=0.
REQ-031 SHALL give Reset priority over Abort and Start, including in the middle of an operation.

Structure
REQ-032 SHALL take the FSM state encoding and the TAMANHO/ADDR_W defaults from a shared package, acumulador_pkg.
REQ-033 SHALL be a single module with no sub-modules; the integration top pairs it with the existing accumulator and memory.

Verification
REQ-034 SHALL pass this case: Reset, then Start with BaseAddr=0x10, Count=3 and memory[0x10..0x12]=5,7,9 -> Done at t+11 and accumulator output 21.
REQ-035 SHALL pass this case: Start with Count=0 after a previous sum of 21 -> Clear low at t+1, Done at t+2, accumulator output 0.
REQ-036 SHALL pass this case: BaseAddr=0xFE, Count=3 -> Addr sequence 0xFE, 0xFF, 0x00 and a correct sum.
REQ-037 SHALL pass this case: Abort asserted in the second LOAD of a Count=4 run -> IDLE next cycle, Done never pulses, accumulator holds the first-word value.
REQ-038 SHALL pass this case: Start pulsed again during Busy -> no restart, and a single Done at the originally predicted cycle.
REQ-039 SHALL pass this case: Reset asserted during XFER -> all outputs at reset values next cycle, then a fresh Start runs correctly.
